// File: rtl/accel_pkg.sv
// Shared 68030-side definitions for the accelerator: bus-cycle states, SIZ codes, memory map.
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    ACK     = 2'd2,
    RECOVER = 2'd3
  } bus_state_t;

  localparam logic [1:0] SIZ_LONG  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_3BYTE = 2'b11;

  localparam logic [2:0] FC_CPU_SPACE = 3'h7;

  // A31:A22 selects a 4 MB window; fast RAM sits at 0x0040_0000-0x007F_FFFF.
  localparam int unsigned ADDR_TOP_LSB   = 22;
  localparam logic [9:0]  FASTRAM_BASE   = 10'h001;
  localparam logic [31:0] FASTRAM_BYTES  = 32'h0040_0000;

  function automatic logic fast_ram_hit(input logic [9:0] top,
                                        input logic [2:0] fc,
                                        input logic [9:0] base);
    return (top == base) && (fc != FC_CPU_SPACE);
  endfunction

endpackage

// File: rtl/byte_lane_decode.sv
// 68030 dynamic bus sizing lane decode for a 32-bit port: SIZ and A1:A0 to active byte lanes.
module byte_lane_decode (
  input  logic [1:0] size,
  input  logic [1:0] addr,
  output logic [3:0] lanes
);

  logic siz0, siz1, a0, a1;
  logic uud, umd, lmd, lld;

  assign siz0 = size[0];
  assign siz1 = size[1];
  assign a0   = addr[0];
  assign a1   = addr[1];

  assign uud = ~a1 & ~a0;
  assign umd = ~a1 & (a0 | ~siz0 | siz1);
  assign lmd = (a1 & ~a0)
             | (~a1 & ((~siz0 & ~siz1) | (siz1 & siz0) | (a0 & ~siz0)));
  assign lld = (a1 & a0) | (a0 & siz0 & siz1) | (~siz0 & ~siz1) | (a1 & siz1);

  // [3]=D31:24 ... [0]=D7:0
  assign lanes = {uud, umd, lmd, lld};

endmodule

// File: rtl/fastram_ctrl.sv
// 68030 fast-RAM SRAM controller: claims window hits, strobes the SRAM, terminates as a 32-bit port.
// DSACK asserts WAIT_STATES+1 clocks after AS is sampled low; misses pass through to the PDS translator.
module fastram_ctrl
  import accel_pkg::*;
#(
  parameter logic [9:0]  RAM_BASE    = FASTRAM_BASE,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic       cpuClock,
  input  logic       cpuReset,
  input  logic       ncpuAS,
  input  logic       ncpuDS,
  input  logic       cpuRnW,
  input  logic [1:0] cpuSize,
  input  logic [1:0] cpuAddrLo,
  input  logic [9:0] cpuAddrTop,
  input  logic [2:0] cpuFC,
  inout  wire        ncpuDsack0,
  inout  wire        ncpuDsack1,
  output logic       npasteInhibit,
  output logic       nramCe,
  output logic       nramOe,
  output logic [3:0] nramWe
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  bus_state_t state;
  logic [2:0] count;
  logic       hit;
  logic       ram_sel;
  logic       dsack_drive;
  logic       dsack_level;
  logic [3:0] lanes;

  // Purely address/FC based so the translator sees it before AS falls.
  assign hit           = fast_ram_hit(cpuAddrTop, cpuFC, RAM_BASE);
  assign npasteInhibit = ~hit;

  byte_lane_decode u_lanes (
    .size  (cpuSize),
    .addr  (cpuAddrLo),
    .lanes (lanes)
  );

  always_ff @(posedge cpuClock or posedge cpuReset) begin
    if (cpuReset) begin
      state       <= IDLE;
      count       <= '0;
      ram_sel     <= 1'b0;
      dsack_drive <= 1'b0;
      dsack_level <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!ncpuAS && hit) begin
            state   <= ACCESS;
            count   <= WS;
            ram_sel <= 1'b1;
          end
        end
        ACCESS: begin
          if (ncpuAS) begin
            state       <= RECOVER;
            ram_sel     <= 1'b0;
            dsack_drive <= 1'b1;
            dsack_level <= 1'b1;
          end else if (count == 3'd0) begin
            state       <= ACK;
            dsack_drive <= 1'b1;
            dsack_level <= 1'b0;
          end else begin
            count <= count - 3'd1;
          end
        end
        ACK: begin
          if (ncpuAS) begin
            state       <= RECOVER;
            ram_sel     <= 1'b0;
            dsack_level <= 1'b1;
          end
        end
        RECOVER: begin
          // Drive DSACK high for this one clock so the shared line negates fast, then release.
          state       <= IDLE;
          dsack_drive <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          ram_sel     <= 1'b0;
          dsack_drive <= 1'b0;
        end
      endcase
    end
  end

  assign nramCe = ~ram_sel;
  assign nramOe = ~(ram_sel & cpuRnW);
  // Write strobes follow DS live so they never open before the CPU has valid data on the bus.
  assign nramWe = (ram_sel && !cpuRnW && !ncpuDS) ? ~lanes : 4'hF;

  assign ncpuDsack0 = dsack_drive ? dsack_level : 1'bz;
  assign ncpuDsack1 = dsack_drive ? dsack_level : 1'bz;

endmodule

// File: tb/tb_fastram_ctrl.sv
// Bench for fastram_ctrl: vector table of 68030 cycles plus abort, reset-in-ACK and back-to-back sequences.
module tb_fastram_ctrl;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       as_n  = 1'b1;
  logic       ds_n  = 1'b1;
  logic       rnw   = 1'b1;
  logic [1:0] siz   = 2'b00;
  logic [1:0] alo   = 2'b00;
  logic [9:0] atop  = 10'h000;
  logic [2:0] fc    = 3'h5;

  wire        dsack0, dsack1, dsack0_5, dsack1_5;
  logic       inh, ce, oe, inh5, ce5, oe5;
  logic [3:0] we, we5;

  fastram_ctrl #(.RAM_BASE(10'h001), .WAIT_STATES(1)) dut (
    .cpuClock(clk), .cpuReset(rst), .ncpuAS(as_n), .ncpuDS(ds_n), .cpuRnW(rnw),
    .cpuSize(siz), .cpuAddrLo(alo), .cpuAddrTop(atop), .cpuFC(fc),
    .ncpuDsack0(dsack0), .ncpuDsack1(dsack1), .npasteInhibit(inh),
    .nramCe(ce), .nramOe(oe), .nramWe(we)
  );

  fastram_ctrl #(.RAM_BASE(10'h001), .WAIT_STATES(5)) dut5 (
    .cpuClock(clk), .cpuReset(rst), .ncpuAS(as_n), .ncpuDS(ds_n), .cpuRnW(rnw),
    .cpuSize(siz), .cpuAddrLo(alo), .cpuAddrTop(atop), .cpuFC(fc),
    .ncpuDsack0(dsack0_5), .ncpuDsack1(dsack1_5), .npasteInhibit(inh5),
    .nramCe(ce5), .nramOe(oe5), .nramWe(we5)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ce;
    logic       oe;
    logic [3:0] we;
    logic       drv;
    logic [1:0] lvl;
  } obs_t;

  typedef struct {
    logic [9:0] top;
    logic [2:0] fc;
    logic       rnw;
    logic [1:0] siz;
    logic [1:0] a;
    logic       ds;
    logic       hit;
    logic [3:0] we;
    string      name;
  } vec_t;

  localparam obs_t IDLE_OBS = {1'b1, 1'b1, 4'hF, 1'b0, 2'b00};

  obs_t expq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Expected pins at sample j after the edge that first sees AS low, AS held low for len edges.
  function automatic obs_t exp_at(int j, int len, int ws, vec_t v);
    obs_t o = IDLE_OBS;
    if (v.hit && j < len) begin
      o.ce = 1'b0;
      o.oe = ~v.rnw;
      if (!v.rnw && !v.ds) o.we = v.we;
      if (j > ws) begin
        o.drv = 1'b1;
        o.lvl = 2'b00;
      end
    end else if (v.hit && j == len) begin
      o.drv = 1'b1;
      o.lvl = 2'b11;
    end
    return o;
  endfunction

  function automatic obs_t sample(bit use5);
    obs_t o;
    if (use5) o = {ce5, oe5, we5, dut5.dsack_drive, dsack1_5, dsack0_5};
    else      o = {ce,  oe,  we,  dut.dsack_drive,  dsack1,   dsack0};
    return o;
  endfunction

  task automatic check_obs(string name, obs_t got, obs_t exp);
    n_vec++;
    if (got.ce !== exp.ce || got.oe !== exp.oe || got.we !== exp.we ||
        got.drv !== exp.drv || (exp.drv && got.lvl !== exp.lvl)) begin
      n_bad++;
      $display("FAIL %s: got ce=%b oe=%b we=%b dsack_drv=%b dsack=%b, want ce=%b oe=%b we=%b dsack_drv=%b dsack=%b",
               name, got.ce, got.oe, got.we, got.drv, got.lvl,
               exp.ce, exp.oe, exp.we, exp.drv, exp.lvl);
    end
  endtask

  task automatic check_bit(string name, logic got, logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, got, exp);
    end
  endtask

  task automatic set_addr(vec_t v);
    atop = v.top;
    fc   = v.fc;
    rnw  = v.rnw;
    siz  = v.siz;
    alo  = v.a;
  endtask

  task automatic run_cycle(vec_t v, int len, int ws, bit use5);
    @(negedge clk);
    set_addr(v);
    as_n = 1'b1;
    ds_n = 1'b1;
    #1 check_bit({v.name, " inhibit"}, use5 ? inh5 : inh, ~v.hit);
    for (int j = 0; j < len + 2; j++) expq.push_back(exp_at(j, len, ws, v));
    @(negedge clk);
    as_n = 1'b0;
    ds_n = v.ds;
    for (int j = 0; j < len + 2; j++) begin
      @(posedge clk);
      #1 check_obs($sformatf("%s j%0d", v.name, j), sample(use5), expq.pop_front());
      if (j == len - 1) begin
        @(negedge clk);
        as_n = 1'b1;
        ds_n = 1'b1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at %0t, limit 100000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[12];
    vec_t v;
    //            top     fc    rnw   siz    a      ds    hit   we
    tbl[0]  = '{10'h001, 3'h5, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 4'hF,    "read long @0"};
    tbl[1]  = '{10'h001, 3'h5, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 4'b1011, "byte wr @1"};
    tbl[2]  = '{10'h001, 3'h5, 1'b0, 2'b10, 2'b10, 1'b0, 1'b1, 4'b1100, "word wr @2"};
    tbl[3]  = '{10'h001, 3'h5, 1'b0, 2'b11, 2'b01, 1'b0, 1'b1, 4'b1000, "3byte wr @1"};
    tbl[4]  = '{10'h001, 3'h5, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 4'b0000, "long wr @0"};
    tbl[5]  = '{10'h001, 3'h1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 4'b0111, "byte wr @0"};
    tbl[6]  = '{10'h001, 3'h1, 1'b0, 2'b01, 2'b11, 1'b0, 1'b1, 4'b1110, "byte wr @3"};
    tbl[7]  = '{10'h001, 3'h2, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 4'b0011, "word wr @0"};
    tbl[8]  = '{10'h001, 3'h5, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 4'b0000, "long wr DS high"};
    tbl[9]  = '{10'h000, 3'h5, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 4'hF,    "miss 0x00200000"};
    tbl[10] = '{10'h001, 3'h7, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'hF,    "cpu space FC7"};
    tbl[11] = '{10'h003, 3'h5, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'hF,    "miss 0x00C00000"};

    #1;
    check_obs("reset ws1", sample(0), IDLE_OBS);
    check_obs("reset ws5", sample(1), IDLE_OBS);
    check_bit("reset inhibit", inh, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_cycle(tbl[i], 4, 1, 1'b0);

    // AS withdrawn while the slow instance is still counting wait states.
    v = tbl[4];
    v.name = "abort ws5";
    run_cycle(v, 3, 5, 1'b1);

    // Reset pulse while DSACK is asserted, then a clean cycle afterwards.
    v = tbl[0];
    @(negedge clk);
    set_addr(v);
    as_n = 1'b1;
    ds_n = 1'b1;
    @(negedge clk);
    as_n = 1'b0;
    ds_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_obs("pre-reset ack", sample(0), exp_at(2, 4, 1, v));
    #2 rst = 1'b1;
    #1 check_obs("async reset in ack", sample(0), IDLE_OBS);
    @(negedge clk);
    rst  = 1'b0;
    as_n = 1'b1;
    ds_n = 1'b1;
    @(posedge clk);
    #1 check_obs("post-reset idle", sample(0), IDLE_OBS);
    v = tbl[4];
    v.name = "after reset long wr";
    run_cycle(v, 4, 1, 1'b0);

    // Back-to-back: AS high for a single clock between two hit cycles.
    v = tbl[0];
    @(negedge clk);
    set_addr(v);
    as_n = 1'b1;
    ds_n = 1'b1;
    for (int j = 0; j < 5; j++) expq.push_back(exp_at(j, 4, 1, v));
    expq.push_back(IDLE_OBS);
    for (int j = 0; j < 6; j++) expq.push_back(exp_at(j, 4, 1, v));
    @(negedge clk);
    as_n = 1'b0;
    ds_n = 1'b0;
    for (int s = 0; s < 12; s++) begin
      @(posedge clk);
      #1 check_obs($sformatf("b2b s%0d", s), sample(0), expq.pop_front());
      if (s == 3 || s == 9) begin
        @(negedge clk);
        as_n = 1'b1;
        ds_n = 1'b1;
      end else if (s == 4) begin
        @(negedge clk);
        as_n = 1'b0;
        ds_n = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fastram_ctrl.md
Name: fastram_ctrl

Overview:
- Onboard 32-bit SRAM controller on the 68030 side of the accelerator, directly upstream of the PDS bus translator.
- Decodes each 68030 cycle. For cycles that hit the fast-RAM window it:
  - claims the cycle and inhibits the PDS translator;
  - drives SRAM chip, output and byte-write enables;
  - terminates the cycle as a 32-bit port via DSACK1/DSACK0 after a fixed number of wait states.
- Misses pass untouched to the PDS translator.

Parameters:
- RAM_BASE, 10'h001, value of cpuAddrTop[31:22] selecting the 4 MB window (0x0040_0000–0x007F_FFFF).
- WAIT_STATES, 1, cpuClock cycles between entering ACCESS and asserting DSACK (range 0–7).

Ports:
- cpuClock  input  1  68030 primary clock; all state changes on its rising edge.
- cpuReset  input  1  asynchronous, active-high reset.
- ncpuAS  input  1  68030 address strobe.
- ncpuDS  input  1  68030 data strobe.
- cpuRnW  input  1  68030 read/write.
- cpuSize  input  2  68030 SIZ1:SIZ0 (00 long, 01 byte, 10 word, 11 three-byte).
- cpuAddrLo  input  2  68030 A1:A0.
- cpuAddrTop  input  10  68030 A31:A22.
- cpuFC  input  3  68030 function code.
- ncpuDsack0  inout  1  tristated termination, active-low.
- ncpuDsack1  inout  1  tristated termination, active-low.
- npasteInhibit  output  1  low = fast RAM owns this cycle; PDS translator must not start a PDS cycle.
- nramCe  output  1  SRAM chip enable.
- nramOe  output  1  SRAM output enable.
- nramWe  output  4  byte write enables: [3]=D31:24, [2]=D23:16, [1]=D15:8, [0]=D7:0.

Behaviour:
- Hit (combinational): cpuAddrTop == RAM_BASE and cpuFC != 3'h7.
- npasteInhibit: combinational, equals ~hit. It is valid before ncpuAS falls, so the translator sees it before sampling AS.
- Reset values (asynchronous, while cpuReset=1):
  - state IDLE, wait counter 0;
  - nramCe=1, nramOe=1, nramWe=4'hF;
  - ncpuDsack0 and ncpuDsack1 = Z.
- States:
  - IDLE: if ncpuAS=0 and hit → ACCESS, and load counter with WAIT_STATES. Otherwise stay.
  - ACCESS:
    - if ncpuAS=1 (aborted cycle) → RECOVER;
    - else if counter==0 → ACK;
    - else decrement the counter.
  - ACK: hold until ncpuAS=1, then → RECOVER.
  - RECOVER: one clock, then → IDLE. Never re-enter ACCESS directly from RECOVER.
- Outputs per state:
  - nramCe=0 in ACCESS and ACK.
  - nramOe=0 in ACCESS and ACK when cpuRnW=1.
  - nramWe lane bit = 0 in ACCESS and ACK only when cpuRnW=0, ncpuDS=0 and the lane is enabled.
  - ncpuDsack1 and ncpuDsack0 both driven 0 in ACK.
  - In RECOVER both DSACKs are actively driven 1 for one clock (fast negation), then return to Z in IDLE.
  - Both DSACKs are Z in IDLE and ACCESS.
- Latency: ncpuAS sampled low at edge n → DSACK asserted after edge n+1+WAIT_STATES.
  - WAIT_STATES=0 gives DSACK after edge n+1.
- Byte lanes:
  - Reads enable all four lanes; the 68030 selects bytes internally.
  - Writes use these enables:
    - UUD = ~A1 & ~A0
    - UMD = ~A1 & (A0 | ~SIZ0 | SIZ1)
    - LMD = A1 & ~A0, or ~A1 & ((~SIZ0 & ~SIZ1) | (SIZ1 & SIZ0) | (A0 & ~SIZ0))
    - LLD = (A1 & A0) | (A0 & SIZ0 & SIZ1) | (~SIZ0 & ~SIZ1) | (A1 & SIZ1)
- Miss cycles: state stays IDLE and DSACKs stay Z, for the whole cycle.
- cpuReset asserted mid-cycle: immediately forces IDLE, releases DSACKs to Z and deasserts all SRAM strobes. The CPU retries after reset.
- ncpuAS negation in any state ends the SRAM access within one clock. No write strobe may extend past RECOVER.

Decomposition:
- Shared package `accel_pkg`:
  - bus-state enum (IDLE, ACCESS, ACK, RECOVER);
  - SIZ encodings;
  - FC_CPU_SPACE = 3'h7;
  - memory-map constants, including RAM_BASE, also reused by the PDS translator decode.
- One natural sub-module: `byte_lane_decode`, pure combinational (SIZ, A1:A0 → 4-bit lane enable). It is reusable by a future 32-bit peripheral port.

Test Plan:
1. Long read at 0x0040_0000, WAIT_STATES=1, AS low at edge 0:
   - npasteInhibit=0 before AS;
   - nramCe=nramOe=0 from edge 1;
   - DSACK1=DSACK0=0 after edge 2;
   - AS high → DSACK driven 1 for one clock, then Z.
2. Write byte lanes at 0x0040_00xx:
   - byte write at offset 1 → nramWe=4'b1011 while DS low;
   - word write at offset 2 → 4'b1100;
   - three-byte write at offset 1 → 4'b1000;
   - long write at offset 0 → 4'b0000.
3. Miss address 0x0020_0000, and CPU-space cycle FC=7 at 0x0040_0000:
   - npasteInhibit=1;
   - nramCe stays 1;
   - DSACKs stay Z.
4. AS negated during ACCESS with WAIT_STATES=5:
   - RECOVER on the next edge, no DSACK asserted, nramWe returns to 4'hF.
5. cpuReset pulsed while in ACK:
   - outputs return to reset values asynchronously;
   - after reset release, a new hit cycle completes normally.
6. Back-to-back hit cycles with one-clock AS high gap:
   - the second cycle is accepted only after RECOVER→IDLE;
   - DSACK timing is identical to scenario 1.
